boot_loader: RTL and testbench

- Byte-stream program loader that sits upstream of the core's instruction memory.
- Receives a length-prefixed image over a valid/ready byte interface and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory, then releases the core's reset.
- The core is held in reset until a complete, valid image has been written.

---
 rtl/boot_loader.sv | 159 +++++++++++++++
 tb/tb_boot_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: length-prefixed byte-stream loader that fills instruction memory.
// Define BOOT_LOADER_CKSUM_EN to require a trailing 8-bit sum byte.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
`ifdef BOOT_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_len;
    logic [31:0] r_word_idx;
    logic [23:0] r_word;
    logic        r_rdy;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_core_rst;
    logic        r_done;
    logic        r_err;
`ifdef BOOT_LOADER_CKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_fire;
    logic [31:0] w_len;
    logic [31:0] w_word;
    logic        w_last;

    // Bytes shift in from the top so the first byte ends up in [7:0].
    assign w_fire = rx_valid & r_rdy;
    assign w_len  = {rx_data, r_len[31:8]};
    assign w_word = {rx_data, r_word};
    assign w_last = (r_word_idx == r_len - 32'd1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_LEN;
            r_byte_cnt <= 2'd0;
            r_len      <= 32'd0;
            r_word_idx <= 32'd0;
            r_word     <= 24'd0;
            r_rdy      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef BOOT_LOADER_CKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_LEN: begin
                    r_rdy <= 1'b1;
                    if (w_fire) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_len      <= w_len;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_len == 32'd0) begin
`ifdef BOOT_LOADER_CKSUM_EN
                                r_state <= S_CKSUM;
`else
                                r_state    <= S_DONE;
                                r_rdy      <= 1'b0;
                                r_core_rst <= 1'b0;
                                r_done     <= 1'b1;
`endif
                            end else if (w_len > MAX_W) begin
                                r_state <= S_ERROR;
                                r_rdy   <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_word     <= w_word[31:8];
`ifdef BOOT_LOADER_CKSUM_EN
                        r_sum      <= r_sum + rx_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_we       <= 1'b1;
                            r_wdata    <= w_word;
                            r_addr     <= BASE_ADDR + {r_word_idx[29:0], 2'b00};
                            r_word_idx <= r_word_idx + 32'd1;
                            if (w_last) begin
`ifdef BOOT_LOADER_CKSUM_EN
                                r_state <= S_CKSUM;
`else
                                r_state    <= S_DONE;
                                r_rdy      <= 1'b0;
                                r_core_rst <= 1'b0;
                                r_done     <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef BOOT_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (w_fire) begin
                        r_rdy <= 1'b0;
                        if (rx_data == r_sum) begin
                            r_state    <= S_DONE;
                            r_core_rst <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_rdy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready   = r_rdy;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_rst;
    assign done       = r_done;
    assign error      = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected writes go into a queue when driven
// and are popped when imem_we fires.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img [4];
    int          vectors = 0;
    int          miscompares = 0;

    boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (done && error)
            check("done_error_excl", {done, error}, 32'd2);
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {31'd0, imem_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("imem_addr", imem_addr, mon_e.a);
                check("imem_wdata", imem_wdata, mon_e.d);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_done_error", {30'd0, done, error}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge CLK);
        check("post_rst_ready", {31'd0, rx_ready}, 32'd1);
    endtask

    // Called just after a negedge: a byte offered now transfers at the next
    // posedge if rx_ready is high, and the task returns at the negedge after.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit got;
        got = 1'b0;
        if (gaps) begin
            rx_valid = 1'b0;
            @(negedge CLK);
        end
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = rx_ready;
            @(negedge CLK);
        end
        if (!got) check("accept_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic load(input int n, input bit gaps, input bit bad);
        logic [31:0] nb;
        logic [7:0]  sum;
        nb = n;
        sum = 8'd0;
        for (int i = 0; i < 4; i++) send_byte(nb[8*i +: 8], gaps);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 3) exp_q.push_back({BASE + 32'(4 * k), img[k]});
                send_byte(img[k][8*i +: 8], gaps);
                sum = sum + img[k][8*i +: 8];
                if (i == 3) check("we_timing", {31'd0, imem_we}, 32'd1);
            end
        end
`ifdef BOOT_LOADER_CKSUM_EN
        check("cksum_ready", {31'd0, rx_ready}, 32'd1);
        check("cksum_not_done", {31'd0, done}, 32'd0);
        send_byte(sum + {7'd0, bad}, gaps);
`endif
        check("end_done", {31'd0, done}, {31'd0, !bad});
        check("end_error", {31'd0, error}, {31'd0, bad});
        check("end_core_reset", {31'd0, core_reset}, {31'd0, bad});
        check("end_rx_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
        @(negedge CLK);
        check("end_we_single", {31'd0, imem_we}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle after release.
        do_reset();
        repeat (3) @(negedge CLK);
        check("idle_core_reset", {31'd0, core_reset}, 32'd1);
        check("idle_done_error", {30'd0, done, error}, 32'd0);

        // Four words back-to-back.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0050_0093;
        img[2] = 32'hdead_beef;
        img[3] = 32'h1234_5678;
        load(4, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        check("done_absorbing", {31'd0, done}, 32'd1);

        // Over-length image is rejected after the 4th length byte.
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("ovl_error", {31'd0, error}, 32'd1);
        check("ovl_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("ovl_core_reset", {31'd0, core_reset}, 32'd1);
        rx_data = 8'h55;
        rx_valid = 1'b1;
        repeat (4) @(negedge CLK);
        check("ovl_error_hold", {30'd0, done, error}, 32'd1);
        rx_valid = 1'b0;

        // Two words with rx_valid toggling.
        do_reset();
        load(2, 1'b1, 1'b0);

        // Empty image.
        do_reset();
        load(0, 1'b0, 1'b0);

        // Reset after 6 payload bytes, then a fresh 1-word image.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 1'b0);
        exp_q.push_back({BASE, 32'haabb_ccdd});
        send_byte(8'hdd, 1'b0);
        send_byte(8'hcc, 1'b0);
        send_byte(8'hbb, 1'b0);
        send_byte(8'haa, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rx_valid = 1'b0;
        do_reset();
        img[0] = 32'h0010_0113;
        load(1, 1'b0, 1'b0);

`ifdef BOOT_LOADER_CKSUM_EN
        do_reset();
        img[0] = 32'h0403_0201;
        load(1, 1'b0, 1'b0);
        do_reset();
        load(1, 1'b0, 1'b1);
`endif

        repeat (2) @(negedge CLK);
        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
